// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default widths,
// frame delimiter and a small index-width helper.
package uart_pkg;

  // Default bus widths for a requester slot.
  localparam int unsigned DefStrW = 1024;
  localparam int unsigned DefLenW = 8;

  // grant_id is a fixed 3-bit port, enough for up to 8 requesters.
  localparam int unsigned GrantW = 3;

  // Frame delimiter emitted by uart_string_handle around every string.
  localparam logic [7:0] Delim = 8'h26;

  // One-hot arbiter FSM encoding. Bit 6 is reserved for future use.
  localparam int unsigned StateW    = 7;
  localparam logic [6:0] StIdle     = 7'b000_0001;
  localparam logic [6:0] StLoad     = 7'b000_0010;
  localparam logic [6:0] StIssue    = 7'b000_0100;
  localparam logic [6:0] StWaitBusy = 7'b000_1000;
  localparam logic [6:0] StWaitDone = 7'b001_0000;
  localparam logic [6:0] StRelease  = 7'b010_0000;

  // Bits needed to index n requesters; never less than one.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans req_i starting at ptr_i and wrapping, and
// returns the first set index.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  int unsigned     base;
  int unsigned     scan_idx;
  logic [IdxW-1:0] sel;

  // Rotate-and-priority-encode; an out-of-range pointer behaves as zero.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    base      = (32'(ptr_i) < N) ? 32'(ptr_i) : 0;
    scan_idx  = 0;
    sel       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = base + i;
      if (scan_idx >= N) begin
        scan_idx = scan_idx - N;
      end
      sel = IdxW'(scan_idx);
      if (!gnt_vld_o && req_i[sel]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = sel;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one uart_string_handle transmit path among
// NUM_REQ requesters. One transfer is in flight at a time; the next requester is only
// picked after the current framed string has completed, failed or timed out.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned STR_W        = DefStrW,
  parameter int unsigned LEN_W        = DefLenW,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*STR_W-1:0] req_string,
  input  logic [NUM_REQ*LEN_W-1:0] req_length,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       req_err,
  output logic [GrantW-1:0]        grant_id,
  output logic                     arb_busy,
  output logic [STR_W-1:0]         tx_string,
  output logic [LEN_W-1:0]         tx_length,
  output logic                     tx_req,
  input  logic                     tx_busy,
  input  logic                     tx_done
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);
  // The counter only has to reach BUSY_TIMEOUT-1 before the abort fires.
  localparam int unsigned CntW = (BUSY_TIMEOUT < 2) ? 1 : $clog2(BUSY_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  logic [StateW-1:0]  state_q, state_d;
  logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]    grant_q, grant_d;
  logic [STR_W-1:0]   tx_string_q, tx_string_d;
  logic [LEN_W-1:0]   tx_length_q, tx_length_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic [IdxW-1:0]    arb_idx;
  logic               arb_vld;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [STR_W-1:0]   sel_string;
  logic [LEN_W-1:0]   sel_length;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_idx_o (arb_idx),
    .gnt_vld_o (arb_vld)
  );

  // Granted requester's data slice and its one-hot ack/err position.
  always_comb begin
    sel_string = req_string[32'(grant_q) * STR_W +: STR_W];
    sel_length = req_length[32'(grant_q) * LEN_W +: LEN_W];
    gnt_oh     = NUM_REQ'(1) << grant_q;
  end

  // FSM next-state, data capture, busy timeout and completion pulses.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tx_string_d = tx_string_q;
    tx_length_d = tx_length_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    err_d       = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_vld) begin
          grant_d = arb_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        tx_string_d = sel_string;
        tx_length_d = sel_length;
        if (sel_length == '0) begin
          // Nothing to send: reject without touching the UART.
          err_d   = gnt_oh;
          state_d = StRelease;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // A busy seen on the last counted cycle still wins over the abort.
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntLast) begin
          err_d   = gnt_oh;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          ack_d   = gnt_oh;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // The just-served requester drops to lowest priority.
        rr_ptr_d = (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers; everything returns to idle values on reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tx_string_q <= '0;
      tx_length_q <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tx_string_q <= tx_string_d;
      tx_length_q <= tx_length_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  // Outputs come straight from registers, so tx_req is a clean one-cycle pulse.
  always_comb begin
    tx_req    = (state_q == StIssue);
    arb_busy  = (state_q != StIdle);
    grant_id  = GrantW'(grant_q);
    tx_string = tx_string_q;
    tx_length = tx_length_q;
    req_ack   = ack_q;
    req_err   = err_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed requests with a scoreboard of expected
// transmit issues and ack/err pulses, checked by an independent monitor.
module tb_uart_tx_arbiter;

  localparam int NReq = 4;
  localparam int StrW = 64;
  localparam int LenW = 8;
  localparam int Tmo  = 15;

  logic                   sys_clk;
  logic                   sys_rst_n;
  logic [NReq-1:0]        req_valid;
  logic [NReq*StrW-1:0]   req_string;
  logic [NReq*LenW-1:0]   req_length;
  logic [NReq-1:0]        req_ack;
  logic [NReq-1:0]        req_err;
  logic [2:0]             grant_id;
  logic                   arb_busy;
  logic [StrW-1:0]        tx_string;
  logic [LenW-1:0]        tx_length;
  logic                   tx_req;
  logic                   tx_busy;
  logic                   tx_done;

  typedef struct {
    logic [2:0]  gid;
    logic [7:0]  len;
    logic [63:0] str;
  } tx_exp_t;

  typedef struct {
    logic       is_err;
    logic [3:0] mask;
    logic [2:0] gid;
  } ev_exp_t;

  tx_exp_t txq[$];
  ev_exp_t evq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int done_gap = 5;
  bit no_busy  = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ      (NReq),
    .STR_W        (StrW),
    .LEN_W        (LenW),
    .BUSY_TIMEOUT (Tmo)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .req_valid  (req_valid),
    .req_string (req_string),
    .req_length (req_length),
    .req_ack    (req_ack),
    .req_err    (req_err),
    .grant_id   (grant_id),
    .arb_busy   (arb_busy),
    .tx_string  (tx_string),
    .tx_length  (tx_length),
    .tx_req     (tx_req),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic void push_tx(input logic [2:0] gid, input logic [7:0] len,
                                  input logic [63:0] str);
    tx_exp_t e;
    e.gid = gid;
    e.len = len;
    e.str = str;
    txq.push_back(e);
  endfunction

  function automatic void push_ev(input logic is_err, input logic [3:0] mask,
                                  input logic [2:0] gid);
    ev_exp_t e;
    e.is_err = is_err;
    e.mask   = mask;
    e.gid    = gid;
    evq.push_back(e);
  endfunction

  // Advance one cycle; requesters drop their request once acked or rejected.
  task automatic step();
    @(negedge sys_clk);
    req_valid = req_valid & ~(req_ack | req_err);
  endtask

  task automatic raise(input int k, input logic [63:0] s, input logic [7:0] len);
    req_string[k*StrW +: StrW] = s;
    req_length[k*LenW +: LenW] = len;
    req_valid[k] = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((req_valid != '0 || arb_busy) && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  // Downstream uart_string_handle stand-in: busy from the tx_req cycle, done after a gap.
  initial begin
    tx_busy = 1'b0;
    tx_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && tx_req && !no_busy) begin
        tx_busy = 1'b1;
        for (int i = 0; i < done_gap && sys_rst_n; i++) @(negedge sys_clk);
        if (sys_rst_n) begin
          tx_done = 1'b1;
          @(negedge sys_clk);
        end
        tx_done = 1'b0;
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: compares every tx_req issue and every ack/err pulse with the scoreboard.
  initial begin
    tx_exp_t         t;
    ev_exp_t         e;
    logic [NReq-1:0] evt;
    bit              prev_evt;
    prev_evt = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_evt = 1'b0;
      end else begin
        if (tx_req) begin
          if (txq.size() == 0) begin
            chk("tx_req_unexpected", 64'd1, 64'd0);
          end else begin
            t = txq.pop_front();
            chk("tx_grant_id", 64'(grant_id), 64'(t.gid));
            chk("tx_length", 64'(tx_length), 64'(t.len));
            chk("tx_string", 64'(tx_string), t.str);
          end
        end
        evt = req_ack | req_err;
        if (evt != '0) begin
          chk("pulse_single_cycle", 64'(prev_evt), 64'd0);
          chk("ack_err_onehot", 64'($countones(evt)), 64'd1);
          if (evq.size() == 0) begin
            chk("event_unexpected", 64'(evt), 64'd0);
          end else begin
            e = evq.pop_front();
            chk("req_ack", 64'(req_ack), e.is_err ? 64'd0 : 64'(e.mask));
            chk("req_err", 64'(req_err), e.is_err ? 64'(e.mask) : 64'd0);
            chk("event_grant_id", 64'(grant_id), 64'(e.gid));
          end
        end
        prev_evt = (evt != '0);
      end
    end
  end

  initial begin
    req_valid  = '0;
    req_string = '0;
    req_length = '0;
    sys_rst_n  = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_tx_req", 64'(tx_req), 64'd0);
    chk("rst_arb_busy", 64'(arb_busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_tx_length", 64'(tx_length), 64'd0);
    chk("rst_tx_string", 64'(tx_string), 64'd0);
    chk("rst_req_ack", 64'(req_ack), 64'd0);
    chk("rst_req_err", 64'(req_err), 64'd0);
    sys_rst_n = 1'b1;

    // Single request "ABC" from requester 1; byte 0 in the low bits.
    done_gap = 40;
    raise(1, 64'h434241, 8'd3);
    push_tx(3'd1, 8'd3, 64'h434241);
    push_ev(1'b0, 4'b0010, 3'd1);
    step();
    chk("t1_no_req_at_1", 64'(tx_req), 64'd0);
    step();
    chk("t1_req_at_2", 64'(tx_req), 64'd1);
    step();
    chk("t1_req_one_cycle", 64'(tx_req), 64'd0);
    wait_idle(200, "t1_complete");
    chk("t1_last_grant", 64'(grant_id), 64'd1);

    // Round robin from pointer 0, two full rounds.
    do_reset();
    done_gap = 3;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NReq; k++) begin
        raise(k, 64'h30 + 64'(k), 8'd1);
        push_tx(3'(k), 8'd1, 64'h30 + 64'(k));
        push_ev(1'b0, 4'(1 << k), 3'(k));
      end
      wait_idle(300, "t2_round_complete");
    end

    // Zero length on requester 2 rejects; requester 3 is served next.
    raise(2, 64'h58, 8'd0);
    raise(3, 64'h51, 8'd1);
    push_ev(1'b1, 4'b0100, 3'd2);
    push_tx(3'd3, 8'd1, 64'h51);
    push_ev(1'b0, 4'b1000, 3'd3);
    step();
    step();
    chk("t3_err_at_2", 64'(req_err), 64'h4);
    chk("t3_no_tx_req", 64'(tx_req), 64'd0);
    wait_idle(200, "t3_complete");

    // Busy never arrives: abort 16 cycles after tx_req.
    no_busy = 1'b1;
    raise(0, 64'h4b4f, 8'd2);
    push_tx(3'd0, 8'd2, 64'h4b4f);
    push_ev(1'b1, 4'b0001, 3'd0);
    step();
    step();
    chk("t4_tx_req", 64'(tx_req), 64'd1);
    repeat (15) step();
    chk("t4_no_err_at_15", 64'(req_err), 64'd0);
    step();
    chk("t4_err_at_16", 64'(req_err), 64'h1);
    step();
    chk("t4_back_idle", 64'(arb_busy), 64'd0);
    no_busy = 1'b0;

    // Reset while waiting for tx_done, then a fresh request is served.
    done_gap = 40;
    raise(1, 64'h4948, 8'd2);
    push_tx(3'd1, 8'd2, 64'h4948);
    repeat (4) step();
    chk("t5_busy_before_rst", 64'(arb_busy), 64'd1);
    chk("t5_grant_before_rst", 64'(grant_id), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    chk("t5_rst_tx_req", 64'(tx_req), 64'd0);
    chk("t5_rst_arb_busy", 64'(arb_busy), 64'd0);
    chk("t5_rst_grant_id", 64'(grant_id), 64'd0);
    chk("t5_rst_tx_length", 64'(tx_length), 64'd0);
    req_valid = '0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    done_gap = 5;
    raise(0, 64'h5a, 8'd1);
    push_tx(3'd0, 8'd1, 64'h5a);
    push_ev(1'b0, 4'b0001, 3'd0);
    step();
    step();
    chk("t5_fresh_tx_req", 64'(tx_req), 64'd1);
    wait_idle(200, "t5_complete");

    repeat (5) step();
    chk("tx_queue_drained", 64'(txq.size()), 64'd0);
    chk("event_queue_drained", 64'(evq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
